// File: rtl/coeff_loader_if.sv
// Coefficient loader bus: load handshake from the upstream source and
// read stream toward the FFT stages.
interface coeff_loader_if #(
  parameter int WIDTH = 22
);
  logic             load_start;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             load_done;
  logic             rd_en;
  logic [WIDTH-1:0] coeff_out;
  logic             coeff_valid;

  modport master (
    output load_start, in_valid, in_data, rd_en,
    input  in_ready, load_done, coeff_out, coeff_valid
  );

  modport slave (
    input  load_start, in_valid, in_data, rd_en,
    output in_ready, load_done, coeff_out, coeff_valid
  );
endinterface

// File: rtl/coeff_loader.sv
// Coefficient table writer/streamer: fills a SIZE x WIDTH RAM from a
// valid/ready stream, then replays it in address order with wraparound.
// Each word packs an 11-bit real part in [21:11] and imaginary in [10:0].
module coeff_loader #(
  parameter int SIZE  = 32,
  parameter int WIDTH = 22
) (
  input logic           clk,
  input logic           rst,
  coeff_loader_if.slave bus
);
  localparam int PW = $clog2(SIZE);
  localparam logic [PW-1:0] LAST = PW'(SIZE - 1);

  typedef enum logic [1:0] {IDLE, LOAD, READY} state_t;

  state_t           state;
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;
  logic             in_ready_r;
  logic             load_done_r;
  logic [WIDTH-1:0] coeff_p1;
  logic             vld_p1;
  logic             wr_en;
  logic [WIDTH-1:0] mem [SIZE];

  // A restart in the same cycle as a transfer discards that word.
  assign wr_en = rst && (state == LOAD) && bus.in_valid && !bus.load_start;

  // Table storage; contents survive reset and are only replaced by loads.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr] <= bus.in_data;
  end

  // Control FSM with registered handshake flags and the read stage.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      wptr        <= '0;
      rptr        <= '0;
      in_ready_r  <= 1'b0;
      load_done_r <= 1'b0;
      vld_p1      <= 1'b0;
      coeff_p1    <= '0;
    end else begin
      case (state)
        IDLE: begin
          vld_p1 <= 1'b0;
          if (bus.load_start) begin
            state      <= LOAD;
            wptr       <= '0;
            in_ready_r <= 1'b1;
          end
        end
        LOAD: begin
          vld_p1 <= 1'b0;
          if (bus.load_start) begin
            wptr <= '0;
          end else if (bus.in_valid) begin
            if (wptr == LAST) begin
              state       <= READY;
              wptr        <= '0;
              rptr        <= '0;
              in_ready_r  <= 1'b0;
              load_done_r <= 1'b1;
            end else begin
              wptr <= wptr + 1'b1;
            end
          end
        end
        READY: begin
          if (bus.load_start) begin
            state       <= LOAD;
            wptr        <= '0;
            in_ready_r  <= 1'b1;
            load_done_r <= 1'b0;
            vld_p1      <= 1'b0;
          end else if (bus.rd_en) begin
            // ---- stage p1: registered table read ----
            coeff_p1 <= mem[rptr];
            vld_p1   <= 1'b1;
            rptr     <= rptr + 1'b1;
          end else begin
            vld_p1 <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          in_ready_r  <= 1'b0;
          load_done_r <= 1'b0;
          vld_p1      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready    = in_ready_r;
  assign bus.load_done   = load_done_r;
  assign bus.coeff_out   = coeff_p1;
  assign bus.coeff_valid = vld_p1;
endmodule

// File: tb/tb_coeff_loader.sv
// Directed bench for coeff_loader: table-driven read stream plus hand-written
// sequences for gapped loads, restarts, load/read collisions and reset.
module tb_coeff_loader;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  coeff_loader_if #(.WIDTH(22)) bus ();

  coeff_loader #(.SIZE(32), .WIDTH(22)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    bit          rd;
    bit          vld;
    logic [21:0] data;
  } vec_t;

  vec_t tbl [40];

  function automatic logic [21:0] wval(input int kind, input int i);
    case (kind)
      0:       return 22'(i * 32'h1001);
      1:       return 22'(i * 32'h20003);
      default: return 22'(32'h3FFFFF - i);
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic start_load();
    bus.load_start = 1'b1;
    step();
    bus.load_start = 1'b0;
    chk("start_in_ready", 32'(bus.in_ready), 32'd1);
    chk("start_load_done", 32'(bus.load_done), 32'd0);
  endtask

  // Writes 32 words; with gappy set, an idle cycle carrying junk precedes each.
  task automatic do_load(input int kind, input bit gappy);
    for (int i = 0; i < 32; i++) begin
      if (gappy) begin
        bus.in_valid = 1'b0;
        bus.in_data  = 22'h2AAAAA;
        step();
      end
      bus.in_valid = 1'b1;
      bus.in_data  = wval(kind, i);
      step();
      if (i < 31) begin
        chk($sformatf("load%0d_ready_%0d", kind, i), 32'(bus.in_ready), 32'd1);
      end else begin
        chk($sformatf("load%0d_ready_end", kind), 32'(bus.in_ready), 32'd0);
        chk($sformatf("load%0d_done", kind), 32'(bus.load_done), 32'd1);
      end
    end
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
  endtask

  task automatic read_run(input int kind, input int first, input int n, input string tag);
    bus.rd_en = 1'b1;
    for (int i = 0; i < n; i++) begin
      step();
      chk($sformatf("%s_vld_%0d", tag, i), 32'(bus.coeff_valid), 32'd1);
      chk($sformatf("%s_data_%0d", tag, i), 32'(bus.coeff_out), 32'(wval(kind, (first + i) % 32)));
    end
    bus.rd_en = 1'b0;
  endtask

  initial begin
    bus.load_start = 1'b0;
    bus.in_valid   = 1'b0;
    bus.in_data    = '0;
    bus.rd_en      = 1'b0;

    for (int j = 0; j < 34; j++) tbl[j] = '{1'b1, 1'b1, wval(0, j % 32)};
    tbl[34] = '{1'b0, 1'b0, wval(0, 1)};
    tbl[35] = '{1'b1, 1'b1, wval(0, 2)};
    tbl[36] = '{1'b0, 1'b0, wval(0, 2)};
    tbl[37] = '{1'b0, 1'b0, wval(0, 2)};
    tbl[38] = '{1'b1, 1'b1, wval(0, 3)};
    tbl[39] = '{1'b0, 1'b0, wval(0, 3)};

    // Reset state, with inputs active to confirm they are ignored.
    bus.load_start = 1'b1;
    bus.rd_en      = 1'b1;
    step();
    step();
    bus.load_start = 1'b0;
    bus.rd_en      = 1'b0;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_load_done", 32'(bus.load_done), 32'd0);
    chk("rst_coeff_valid", 32'(bus.coeff_valid), 32'd0);
    chk("rst_coeff_out", 32'(bus.coeff_out), 32'd0);
    rst = 1'b1;
    step();
    chk("idle_in_ready", 32'(bus.in_ready), 32'd0);

    // Back-to-back load of index*0x1001, then table-driven read stream.
    start_load();
    do_load(0, 1'b0);
    for (int j = 0; j < 40; j++) begin
      bus.rd_en = tbl[j].rd;
      step();
      chk($sformatf("tbl_vld_%0d", j), 32'(bus.coeff_valid), 32'(tbl[j].vld));
      chk($sformatf("tbl_data_%0d", j), 32'(bus.coeff_out), 32'(tbl[j].data));
    end
    bus.rd_en = 1'b0;

    // Gapped load, then pulsed reads with junk in_valid that must be ignored.
    start_load();
    do_load(1, 1'b1);
    for (int i = 0; i < 32; i++) begin
      bus.rd_en    = 1'b1;
      bus.in_valid = 1'b0;
      step();
      chk($sformatf("gap_vld_%0d", i), 32'(bus.coeff_valid), 32'd1);
      chk($sformatf("gap_data_%0d", i), 32'(bus.coeff_out), 32'(wval(1, i)));
      bus.rd_en    = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_data  = 22'h3FFFFF;
      step();
      chk($sformatf("gap_idle_vld_%0d", i), 32'(bus.coeff_valid), 32'd0);
      chk($sformatf("gap_idle_data_%0d", i), 32'(bus.coeff_out), 32'(wval(1, i)));
    end
    bus.in_valid = 1'b0;

    // Restart after word 10; the same-cycle transfer must be discarded.
    start_load();
    for (int i = 0; i <= 10; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 22'h111111;
      step();
    end
    bus.load_start = 1'b1;
    bus.in_data    = 22'h222222;
    step();
    bus.load_start = 1'b0;
    bus.in_valid   = 1'b0;
    chk("restart_in_ready", 32'(bus.in_ready), 32'd1);
    chk("restart_load_done", 32'(bus.load_done), 32'd0);
    do_load(2, 1'b0);
    read_run(2, 0, 32, "fresh");

    // load_start beats a same-cycle rd_en in READY.
    bus.load_start = 1'b1;
    bus.rd_en      = 1'b1;
    step();
    bus.load_start = 1'b0;
    bus.rd_en      = 1'b0;
    chk("coll_vld", 32'(bus.coeff_valid), 32'd0);
    chk("coll_load_done", 32'(bus.load_done), 32'd0);
    chk("coll_in_ready", 32'(bus.in_ready), 32'd1);
    chk("coll_data_hold", 32'(bus.coeff_out), 32'(wval(2, 31)));

    // Reset in the middle of a read stream.
    do_load(0, 1'b0);
    read_run(0, 0, 5, "pre_rst");
    bus.rd_en = 1'b1;
    rst = 1'b0;
    step();
    rst = 1'b1;
    chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("mid_rst_load_done", 32'(bus.load_done), 32'd0);
    chk("mid_rst_vld", 32'(bus.coeff_valid), 32'd0);
    chk("mid_rst_data", 32'(bus.coeff_out), 32'd0);
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 22'h155555;
      step();
      chk($sformatf("post_rst_vld_%0d", i), 32'(bus.coeff_valid), 32'd0);
      chk($sformatf("post_rst_data_%0d", i), 32'(bus.coeff_out), 32'd0);
      chk($sformatf("post_rst_ready_%0d", i), 32'(bus.in_ready), 32'd0);
    end
    bus.in_valid = 1'b0;
    bus.rd_en    = 1'b0;
    start_load();
    do_load(1, 1'b0);
    read_run(1, 0, 3, "reload");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/coeff_loader.md
COEFF_LOADER -- requirements
Module: coeff_loader

Interface
REQ-001 Parameter SIZE, default 32, number of coefficient words held.
REQ-002 Parameter WIDTH, default 22, coefficient word width: bits [21:11] real, bits [10:0] imaginary, 11-bit each.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low (rst=0 sampled at a clk edge resets the block).
REQ-005 load_start  input  1  request to (re)load the table from word 0.
REQ-006 in_valid  input  1  in_data carries a coefficient word.
REQ-007 in_data  input  WIDTH  coefficient word to store.
REQ-008 in_ready  output  1  block accepts in_data this cycle.
REQ-009 load_done  output  1  level; all SIZE words stored, table readable.
REQ-010 rd_en  input  1  request next coefficient of the stream.
REQ-011 coeff_out  output  WIDTH  registered coefficient read from the table.
REQ-012 coeff_valid  output  1  coeff_out updated by a read in the previous cycle.

Function
REQ-013 Block SHALL be the write side of the coefficient table: it fills an internal SIZE x WIDTH RAM, then streams it in address order 0..SIZE-1, as the FFT stages consume twiddles.
REQ-014 FSM states SHALL be IDLE, LOAD, READY.
REQ-015 IDLE: in_ready=0, load_done=0; load_start=1 -> LOAD with write pointer wptr=0.
REQ-016 LOAD: in_ready=1; a transfer occurs when in_valid=1 and in_ready=1, writing in_data to mem[wptr] and incrementing wptr.
REQ-017 Transfer with wptr=SIZE-1 SHALL write the last word and move to READY on the same edge; in_ready=0 from the next cycle.
REQ-018 in_valid=1 while in_ready=0 SHALL be ignored; no write, no pointer change.
REQ-019 READY: load_done=1, in_ready=0; read pointer rptr starts at 0 on entry.
REQ-020 READY with rd_en=1: coeff_out <= mem[rptr], coeff_valid <= 1 (one-cycle latency); rptr increments, wrapping SIZE-1 -> 0.
REQ-021 READY with rd_en=0: coeff_valid <= 0, coeff_out holds its value, rptr holds.
REQ-022 rd_en=1 in IDLE or LOAD SHALL be ignored; coeff_valid=0.
REQ-023 load_start=1 in LOAD SHALL restart: wptr=0, any same-cycle in_valid transfer is discarded, state stays LOAD.
REQ-024 load_start=1 in READY SHALL win over a same-cycle rd_en: no read, coeff_valid <= 0, load_done <= 0, wptr=0, state -> LOAD.
REQ-025 Words already stored SHALL persist until overwritten; only the state controls readability.
REQ-026 Pointer widths SHALL be ceil(log2(SIZE)); SIZE a power of two, at least 2.

Reset
REQ-027 rst=0 at a clk edge SHALL set state=IDLE, wptr=0, rptr=0, in_ready=0, load_done=0, coeff_valid=0, coeff_out=0; RAM contents need not be cleared.
REQ-028 Reset during LOAD or READY SHALL abort the operation; a full new load is required before reads are served again.
REQ-029 While rst=0, all inputs SHALL be ignored.

Verification
REQ-030 Reset, load_start, 32 back-to-back words with value = index * 0x1001 -> in_ready drops after word 31, load_done=1 the next cycle.
REQ-031 After load, rd_en held for 34 cycles -> coeff_out sequence 0x000000, 0x001001, ..., word 31, then word 0 and word 1 (wrap); coeff_valid=1 starting one cycle after rd_en.
REQ-032 Load with in_valid toggling every other cycle, then rd_en pulses with gaps -> stored data and read order are unchanged; coeff_valid high only the cycle after each rd_en pulse.
REQ-033 load_start asserted after word 10 of a load, then 32 fresh words 0x3FFFFF - index -> reads return only the fresh values starting at index 0.
REQ-034 load_start and rd_en both 1 in READY -> coeff_valid=0 next cycle, load_done=0, in_ready=1.
REQ-035 rst=0 mid-read stream -> all outputs 0 next cycle; rd_en ignored until a new full load completes.
